// File: rtl/multi_dial_poller.sv
// Multi-channel rotary encoder poller: per-channel sync, debounce and quadrature decode feeding
// saturating, optionally accelerated accumulators that are snapshotted onto a valid/ready stream.
module multi_dial_poller #(
    parameter int CHANNELS        = 2,
    parameter int CNT_W           = 8,
    parameter int POLL_TICKS      = 16_000_000 / 10,
    parameter int DEBOUNCE_CYCLES = 16_000_000 / 100,
    parameter int ACCEL_THRESH    = 4,
    parameter int ACCEL_SHIFT     = 2,
    parameter int EMIT_ZERO       = 0
) (
    input  logic                      aclk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       ck,
    input  logic [CHANNELS-1:0]       dt,
    output logic [CHANNELS*CNT_W-1:0] out_delta,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS-1:0]       ovf,
    input  logic                      ovf_clr
);

    localparam int PCW = (POLL_TICKS > 1) ? $clog2(POLL_TICKS) : 1;
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SCW = $clog2(ACCEL_THRESH + 2);
    localparam int SW  = CNT_W + ACCEL_SHIFT + 2;

    localparam logic [PCW-1:0]       POLL_RELOAD = PCW'(POLL_TICKS - 1);
    localparam logic [DBW-1:0]       DB_FULL     = DBW'(DEBOUNCE_CYCLES);
    localparam logic [SCW-1:0]       STEP_SAT    = SCW'(ACCEL_THRESH);
    localparam logic signed [SW-1:0] ACC_MAX     = SW'((1 << (CNT_W - 1)) - 1);
    localparam logic signed [SW-1:0] ACC_MIN     = -ACC_MAX;
    localparam logic signed [SW-1:0] STEP_ONE    = SW'(1);
    localparam logic signed [SW-1:0] STEP_FAST   = SW'(1 << ACCEL_SHIFT);

    localparam logic [0:0] S_COUNT = 1'b0;
    localparam logic [0:0] S_HOLD  = 1'b1;

    // Pairs are packed {ck, dt}
    logic [1:0]              sync1_q  [CHANNELS];
    logic [1:0]              sync2_q  [CHANNELS];
    logic [1:0]              cand_q   [CHANNELS];
    logic [1:0]              stable_q [CHANNELS];
    logic [1:0]              stable_d [CHANNELS];
    logic [DBW-1:0]          run_q    [CHANNELS];
    logic [DBW-1:0]          run_d    [CHANNELS];
    logic [SCW-1:0]          stepCnt_q[CHANNELS];
    logic [SCW-1:0]          stepCnt_d[CHANNELS];
    logic signed [CNT_W-1:0] acc_q    [CHANNELS];
    logic signed [CNT_W-1:0] acc_d    [CHANNELS];

    logic [CHANNELS*CNT_W-1:0] outDelta_q, outDelta_d;
    logic [CHANNELS-1:0]       ovf_q, ovf_d;
    logic [PCW-1:0]            pollCnt_q, pollCnt_d;
    logic [0:0]                state_q, state_d;

    logic pollTick;
    logic anyNonZero;
    logic snapshot;

    // Synchroniser chain is left unreset so reset can adopt the live encoder position.
    always_ff @(posedge aclk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            sync1_q[i] <= {ck[i], dt[i]};
            sync2_q[i] <= sync1_q[i];
            cand_q[i]  <= sync2_q[i];
        end
    end

    always_comb begin
        pollTick   = (pollCnt_q == '0);
        pollCnt_d  = pollTick ? POLL_RELOAD : pollCnt_q - PCW'(1);
        anyNonZero = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (acc_q[i] != '0) begin
                anyNonZero = 1'b1;
            end
        end
        snapshot   = (state_q == S_COUNT) && pollTick && (anyNonZero || (EMIT_ZERO != 0));
        state_d    = state_q;
        outDelta_d = outDelta_q;
        if (snapshot) begin
            state_d = S_HOLD;
            for (int i = 0; i < CHANNELS; i++) begin
                outDelta_d[i*CNT_W +: CNT_W] = acc_q[i];
            end
        end else if ((state_q == S_HOLD) && out_ready) begin
            state_d = S_COUNT;
        end
    end

    // A step landing on a poll tick belongs to the window that starts there.
    always_comb begin
        logic signed [SW-1:0] accBase;
        logic signed [SW-1:0] stepMag;
        logic signed [SW-1:0] sum;
        logic [SCW-1:0]       cntBase;
        logic                 accept;
        logic                 stepEv;
        accBase = '0;
        stepMag = STEP_ONE;
        sum     = '0;
        cntBase = '0;
        accept  = 1'b0;
        stepEv  = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sync2_q[i] != cand_q[i]) begin
                run_d[i] = DBW'(1);
            end else if (run_q[i] == DB_FULL) begin
                run_d[i] = run_q[i];
            end else begin
                run_d[i] = run_q[i] + DBW'(1);
            end
            accept      = (run_d[i] == DB_FULL) && (sync2_q[i] != stable_q[i]);
            stable_d[i] = accept ? sync2_q[i] : stable_q[i];
            stepEv      = accept && !stable_q[i][1] && sync2_q[i][1];

            cntBase = pollTick ? '0 : stepCnt_q[i];
            stepMag = ((ACCEL_THRESH != 0) && (cntBase >= STEP_SAT)) ? STEP_FAST : STEP_ONE;
            accBase = snapshot ? '0 : SW'(acc_q[i]);
            sum     = sync2_q[i][0] ? (accBase - stepMag) : (accBase + stepMag);

            acc_d[i]     = accBase[CNT_W-1:0];
            stepCnt_d[i] = cntBase;
            ovf_d[i]     = ovf_clr ? 1'b0 : ovf_q[i];
            if (stepEv) begin
                stepCnt_d[i] = (cntBase == STEP_SAT) ? cntBase : cntBase + SCW'(1);
                if (sum > ACC_MAX) begin
                    acc_d[i] = ACC_MAX[CNT_W-1:0];
                    ovf_d[i] = 1'b1;
                end else if (sum < ACC_MIN) begin
                    acc_d[i] = ACC_MIN[CNT_W-1:0];
                    ovf_d[i] = 1'b1;
                end else begin
                    acc_d[i] = sum[CNT_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            pollCnt_q  <= POLL_RELOAD;
            state_q    <= S_COUNT;
            outDelta_q <= '0;
            ovf_q      <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                stable_q[i]  <= sync2_q[i];
                run_q[i]     <= DB_FULL;
                stepCnt_q[i] <= '0;
                acc_q[i]     <= '0;
            end
        end else begin
            pollCnt_q  <= pollCnt_d;
            state_q    <= state_d;
            outDelta_q <= outDelta_d;
            ovf_q      <= ovf_d;
            for (int i = 0; i < CHANNELS; i++) begin
                stable_q[i]  <= stable_d[i];
                run_q[i]     <= run_d[i];
                stepCnt_q[i] <= stepCnt_d[i];
                acc_q[i]     <= acc_d[i];
            end
        end
    end

    assign out_delta = outDelta_q;
    assign out_valid = (state_q == S_HOLD);
    assign ovf       = ovf_q;

endmodule
